histogram_reader: RTL and testbench
===================================

HISTOGRAM_READER -- requirements
Module: histogram_reader

Interface
REQ-001 Parameter ADDR_WIDTH, default 9, bin address width.
REQ-002 Parameter DATA_WIDTH, default 16, bin count width.
REQ-003 Parameter NUM_BINS, default 512, number of bins dumped.
REQ-004 Parameter RD_LATENCY, default 2, clocks from address change to valid bin data.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 bram_reset_done  input  1  high once the histogram memory is cleared and counting.
REQ-008 cmd_byte  input  8  command byte from the UART receiver.
REQ-009 cmd_valid  input  1  one-cycle strobe qualifying cmd_byte.
REQ-010 tx_byte  output  8  byte to the UART transmitter.
REQ-011 tx_valid  output  1  tx_byte is valid.
REQ-012 tx_ready  input  1  transmitter accepts tx_byte this cycle.
REQ-013 bin_address_to_hist  output  ADDR_WIDTH  bin read address, histogram port B.
REQ-014 data_from_hist  input  DATA_WIDTH  bin count returned for bin_address_to_hist.
REQ-015 clear_to_hist  output  1  one-cycle request to zero all bins.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 States: IDLE, SEND_HDR, SET_ADDR, WAIT_RD, SEND_MSB, SEND_LSB, CLEAR, CLEAR_WAIT.
REQ-018 IDLE shall accept a command only when cmd_valid=1 and bram_reset_done=1.
REQ-019 Command 0x52 ('R') shall go to SEND_HDR, and command 0x43 ('C') shall go to CLEAR.
REQ-020 Any other byte, any byte received outside IDLE, and any byte received while bram_reset_done=0 shall be dropped with no response.
REQ-021 Byte transfer occurs on tx_valid&&tx_ready; tx_byte shall stay stable and tx_valid shall stay high until the transfer.
REQ-022 SEND_HDR shall present 0xA5, then on transfer clear the address counter to 0 and go to SET_ADDR.
REQ-023 SET_ADDR shall drive bin_address_to_hist with the counter and go to WAIT_RD.
REQ-024 WAIT_RD shall hold for RD_LATENCY cycles, then capture data_from_hist into a DATA_WIDTH register and go to SEND_MSB.
REQ-025 SEND_MSB shall send captured[15:8]; SEND_LSB shall send captured[7:0].
REQ-026 After the LSB transfer, if the counter equals NUM_BINS-1 the block shall go to IDLE; otherwise it shall increment the counter and go to SET_ADDR.
REQ-027 A full dump shall be exactly 1+2*NUM_BINS bytes in ascending bin order, with no wrap-around and no repeated bin.
REQ-028 bin_address_to_hist shall be held constant from SET_ADDR through SEND_LSB of the same bin.
REQ-029 CLEAR shall assert clear_to_hist for exactly one cycle, then go to CLEAR_WAIT.
REQ-030 CLEAR_WAIT shall count NUM_BINS+8 cycles, then go to IDLE; no TX bytes are produced by a clear.
REQ-031 tx_ready held low shall stall the FSM indefinitely without data loss.
REQ-032 A count of 0xFFFF shall be sent unmodified.

Reset
REQ-033 Reset assertion shall immediately force IDLE, tx_valid=0, tx_byte=0, clear_to_hist=0, busy=0, bin_address_to_hist=0, and clear all counters and the capture register.
REQ-034 Reset asserted mid-dump shall abort the dump; after deassertion no remaining bytes are sent.
REQ-035 The first command shall be accepted on the first clock after deassertion at which bram_reset_done=1.

Structure
REQ-036 Package histogram_pkg shall hold ADDR_WIDTH, DATA_WIDTH, NUM_BINS, command codes 0x52/0x43, header 0xA5, and the state encoding.
REQ-037 The block shall be a single module with no sub-module; the BRAM remains inside the histogram block.

Verification
REQ-038 Bench scenario: bins 0..511 preloaded with value=address, 'R', tx_ready=1 -> bytes A5,00,00,00,01,...,01,FF (1025 bytes), then busy=0.
REQ-039 Bench scenario: 'R' with tx_ready toggled pseudo-randomly and bin 7=0xFFFF -> identical byte stream containing FF,FF at bin 7, and tx_byte never changes while tx_valid&&!tx_ready.
REQ-040 Bench scenario: 'C' -> clear_to_hist high for exactly 1 cycle, busy for 521 cycles, and a subsequent 'R' returns all 0x00 after A5.
REQ-041 Bench scenario: 'R' then another 'R' and a 'C' injected mid-dump -> both ignored, a single 1025-byte dump, and clear_to_hist never asserted.
REQ-042 Bench scenario: bram_reset_done=0 with 'R' sent -> no output; 'R' resent after bram_reset_done=1 -> dump starts.
REQ-043 Bench scenario: reset asserted after byte 100 of a dump -> outputs zero asynchronously, no further bytes, and a new 'R' starts again at A5, bin 0.

Source files
------------

// File: rtl/histogram_pkg.sv
// Shared constants, command codes and state encoding for the histogram dump reader.
package histogram_pkg;

  localparam int ADDR_WIDTH = 9;
  localparam int DATA_WIDTH = 16;
  localparam int NUM_BINS   = 512;
  localparam int RD_LATENCY = 2;

  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_CLEAR = 8'h43;
  localparam logic [7:0] HDR_BYTE  = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    SEND_HDR,
    SET_ADDR,
    WAIT_RD,
    SEND_MSB,
    SEND_LSB,
    CLEAR,
    CLEAR_WAIT
  } state_t;

endpackage

// File: rtl/histogram_reader_if.sv
// Bundle of UART command/transmit handshakes and histogram port-B signals.
interface histogram_reader_if #(
  parameter int ADDR_WIDTH = histogram_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = histogram_pkg::DATA_WIDTH
);

  logic                  bram_reset_done;
  logic [7:0]            cmd_byte;
  logic                  cmd_valid;
  logic [7:0]            tx_byte;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [ADDR_WIDTH-1:0] bin_address_to_hist;
  logic [DATA_WIDTH-1:0] data_from_hist;
  logic                  clear_to_hist;
  logic                  busy;

  modport master (
    input  bram_reset_done, cmd_byte, cmd_valid, tx_ready, data_from_hist,
    output tx_byte, tx_valid, bin_address_to_hist, clear_to_hist, busy
  );

  modport slave (
    output bram_reset_done, cmd_byte, cmd_valid, tx_ready, data_from_hist,
    input  tx_byte, tx_valid, bin_address_to_hist, clear_to_hist, busy
  );

endinterface

// File: rtl/histogram_reader.sv
// Serves 'R' (dump header plus every bin MSB-first over the UART) and 'C' (clear all bins)
// commands against the histogram memory's read port.
module histogram_reader #(
  parameter int ADDR_WIDTH = histogram_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = histogram_pkg::DATA_WIDTH,
  parameter int NUM_BINS   = histogram_pkg::NUM_BINS,
  parameter int RD_LATENCY = histogram_pkg::RD_LATENCY
) (
  input  logic               clk,
  input  logic               reset,
  histogram_reader_if.master bus
);
  import histogram_pkg::*;

  // One counter serves both the read-latency wait and the post-clear wait.
  localparam int CNT_W = $clog2(NUM_BINS + 9);

  state_t                state;
  state_t                next_state;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic [CNT_W-1:0]      wait_cnt;
  logic [DATA_WIDTH-1:0] captured;

  logic       last_bin;
  logic       rd_done;
  logic       clr_done;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       clear_pulse;
  logic       busy;

  assign last_bin = (addr_cnt == ADDR_WIDTH'(NUM_BINS - 1));
  assign rd_done  = (wait_cnt == CNT_W'(RD_LATENCY - 1));
  assign clr_done = (wait_cnt == CNT_W'(NUM_BINS + 7));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.cmd_valid && bus.bram_reset_done) begin
          if (bus.cmd_byte == CMD_READ) begin
            next_state = SEND_HDR;
          end else if (bus.cmd_byte == CMD_CLEAR) begin
            next_state = CLEAR;
          end
        end
      end
      SEND_HDR: begin
        if (bus.tx_ready) next_state = SET_ADDR;
      end
      SET_ADDR: next_state = WAIT_RD;
      WAIT_RD: begin
        if (rd_done) next_state = SEND_MSB;
      end
      SEND_MSB: begin
        if (bus.tx_ready) next_state = SEND_LSB;
      end
      SEND_LSB: begin
        if (bus.tx_ready) next_state = last_bin ? IDLE : SET_ADDR;
      end
      CLEAR: next_state = CLEAR_WAIT;
      CLEAR_WAIT: begin
        if (clr_done) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Bytes come straight from state and the capture register, so they hold steady through stalls.
  always_comb begin
    tx_byte     = 8'h00;
    tx_valid    = 1'b0;
    clear_pulse = 1'b0;
    busy        = (state != IDLE);
    case (state)
      SEND_HDR: begin
        tx_valid = 1'b1;
        tx_byte  = HDR_BYTE;
      end
      SEND_MSB: begin
        tx_valid = 1'b1;
        tx_byte  = captured[15:8];
      end
      SEND_LSB: begin
        tx_valid = 1'b1;
        tx_byte  = captured[7:0];
      end
      CLEAR: clear_pulse = 1'b1;
      default: ;
    endcase
  end

  // The address only moves on the header or LSB handshake, keeping it fixed for a whole bin.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_cnt <= '0;
      wait_cnt <= '0;
      captured <= '0;
    end else begin
      case (state)
        SEND_HDR: begin
          if (bus.tx_ready) addr_cnt <= '0;
        end
        SET_ADDR: wait_cnt <= '0;
        WAIT_RD: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (rd_done) captured <= bus.data_from_hist;
        end
        SEND_LSB: begin
          if (bus.tx_ready && !last_bin) addr_cnt <= addr_cnt + 1'b1;
        end
        CLEAR: wait_cnt <= '0;
        CLEAR_WAIT: wait_cnt <= wait_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.tx_byte             = tx_byte;
  assign bus.tx_valid            = tx_valid;
  assign bus.clear_to_hist       = clear_pulse;
  assign bus.busy                = busy;
  assign bus.bin_address_to_hist = addr_cnt;

endmodule

// File: tb/tb_histogram_reader.sv
// Directed-plus-random bench for histogram_reader: a two-cycle BRAM model feeds the reader and
// every UART byte is checked against a stream built from the bench's own copy of the bins.
module tb_histogram_reader;
  import histogram_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  histogram_reader_if bus ();

  histogram_reader dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  logic [15:0] hist_mem [NUM_BINS];
  logic [15:0] ref_mem  [NUM_BINS];
  logic [15:0] rd_pipe;
  logic [7:0]  rx_q [$];

  int pass_cnt    = 0;
  int total_cnt   = 0;
  int clr_cycles  = 0;
  int busy_cycles = 0;
  int stall_err   = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte  = 8'h00;

  // Histogram port B: address registered, then output registered; clear zeroes every bin.
  always @(posedge clk) begin
    rd_pipe            <= hist_mem[bus.bin_address_to_hist];
    bus.data_from_hist <= rd_pipe;
    if (bus.clear_to_hist) begin
      for (int i = 0; i < NUM_BINS; i++) hist_mem[i] <= '0;
    end
  end

  // Observe on the falling edge: record transfers, stall stability, clear and busy cycles.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.tx_valid && bus.tx_ready) rx_q.push_back(bus.tx_byte);
      if (prev_stall && (!bus.tx_valid || bus.tx_byte !== prev_byte)) stall_err++;
      if (bus.clear_to_hist) clr_cycles++;
      if (bus.busy) busy_cycles++;
      prev_stall = bus.tx_valid && !bus.tx_ready;
      prev_byte  = bus.tx_byte;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [7:0] cmd);
    bus.cmd_byte  = cmd;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_byte  = 8'h00;
  endtask

  task automatic wait_idle(input bit rand_ready, output bit timed_out);
    timed_out = 1'b1;
    for (int n = 0; n < 20000; n++) begin
      if (rand_ready) bus.tx_ready = ($urandom_range(0, 2) != 0);
      tick();
      if (!bus.busy) begin
        timed_out = 1'b0;
        break;
      end
    end
    bus.tx_ready = 1'b1;
  endtask

  task automatic wait_bytes(input int count, output bit timed_out);
    timed_out = 1'b1;
    for (int n = 0; n < 5000; n++) begin
      tick();
      if (rx_q.size() >= count) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  // Expected dump: header, then each bin high byte then low byte, ascending.
  task automatic compare_stream(input string tag);
    logic [7:0] exp_q [$];
    int errs;
    int n;
    errs = 0;
    exp_q.push_back(HDR_BYTE);
    for (int b = 0; b < NUM_BINS; b++) begin
      exp_q.push_back(ref_mem[b][15:8]);
      exp_q.push_back(ref_mem[b][7:0]);
    end
    check_output({tag, "_len"}, rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (rx_q[i] !== exp_q[i]) errs++;
    end
    check_output({tag, "_byte_errors"}, errs, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_tx_valid"}, bus.tx_valid, 0);
    check_output({tag, "_tx_byte"}, bus.tx_byte, 0);
    check_output({tag, "_busy"}, bus.busy, 0);
    check_output({tag, "_addr"}, bus.bin_address_to_hist, 0);
    check_output({tag, "_clear"}, bus.clear_to_hist, 0);
  endtask

  initial begin
    bit to;
    int saved;
    logic [15:0] v;

    rst_n               = 1'b0;
    bus.cmd_byte        = 8'h00;
    bus.cmd_valid       = 1'b0;
    bus.tx_ready        = 1'b1;
    bus.bram_reset_done = 1'b0;
    for (int b = 0; b < NUM_BINS; b++) begin
      hist_mem[b] = 16'(b);
      ref_mem[b]  = 16'(b);
    end

    #12;
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    $display("[TB] commands dropped while memory not ready or unknown");
    apply_stimulus(CMD_READ);
    repeat (20) tick();
    check_output("not_ready_busy", bus.busy, 0);
    check_output("not_ready_bytes", rx_q.size(), 0);
    bus.bram_reset_done = 1'b1;
    apply_stimulus(8'h58);
    repeat (5) tick();
    check_output("bad_cmd_busy", bus.busy, 0);

    $display("[TB] ramp dump, transmitter always ready");
    apply_stimulus(CMD_READ);
    check_output("ramp_accept", bus.busy, 1);
    wait_idle(1'b0, to);
    check_output("ramp_timeout", to, 0);
    compare_stream("ramp");
    check_output("ramp_bin1_msb", rx_q[3], 8'h00);
    check_output("ramp_bin1_lsb", rx_q[4], 8'h01);
    check_output("ramp_last_msb", rx_q[1023], 8'h01);
    check_output("ramp_last_lsb", rx_q[1024], 8'hFF);
    check_output("ramp_busy_after", bus.busy, 0);

    $display("[TB] random bins, random backpressure");
    rx_q.delete();
    for (int b = 0; b < NUM_BINS; b++) begin
      v = 16'($urandom);
      hist_mem[b] = v;
      ref_mem[b]  = v;
    end
    hist_mem[7] = 16'hFFFF;
    ref_mem[7]  = 16'hFFFF;
    stall_err   = 0;
    apply_stimulus(CMD_READ);
    wait_idle(1'b1, to);
    check_output("random_timeout", to, 0);
    compare_stream("random");
    check_output("random_bin7_msb", rx_q[15], 8'hFF);
    check_output("random_bin7_lsb", rx_q[16], 8'hFF);
    check_output("stall_stability", stall_err, 0);

    $display("[TB] clear then read back");
    rx_q.delete();
    clr_cycles  = 0;
    busy_cycles = 0;
    apply_stimulus(CMD_CLEAR);
    wait_idle(1'b0, to);
    check_output("clear_timeout", to, 0);
    check_output("clear_pulse_cycles", clr_cycles, 1);
    check_output("clear_busy_cycles", busy_cycles, NUM_BINS + 9);
    check_output("clear_no_bytes", rx_q.size(), 0);
    for (int b = 0; b < NUM_BINS; b++) ref_mem[b] = '0;
    apply_stimulus(CMD_READ);
    wait_idle(1'b0, to);
    check_output("cleared_timeout", to, 0);
    compare_stream("cleared");

    $display("[TB] commands injected mid-dump");
    rx_q.delete();
    for (int b = 0; b < NUM_BINS; b++) begin
      v = 16'($urandom);
      hist_mem[b] = v;
      ref_mem[b]  = v;
    end
    clr_cycles = 0;
    apply_stimulus(CMD_READ);
    wait_bytes(21, to);
    check_output("inject_wait_timeout", to, 0);
    apply_stimulus(CMD_READ);
    apply_stimulus(CMD_CLEAR);
    wait_idle(1'b0, to);
    check_output("inject_timeout", to, 0);
    compare_stream("inject");
    check_output("inject_no_clear", clr_cycles, 0);

    $display("[TB] reset in the middle of a dump");
    rx_q.delete();
    apply_stimulus(CMD_READ);
    wait_bytes(100, to);
    check_output("abort_wait_timeout", to, 0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (3) tick();
    rst_n = 1'b1;
    saved = rx_q.size();
    repeat (50) tick();
    check_output("abort_no_more_bytes", rx_q.size(), saved);
    check_output("abort_idle", bus.busy, 0);
    rx_q.delete();
    apply_stimulus(CMD_READ);
    check_output("restart_accept", bus.busy, 1);
    wait_idle(1'b0, to);
    check_output("restart_timeout", to, 0);
    compare_stream("restart");
    check_output("restart_header", rx_q[0], HDR_BYTE);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
